// File: rtl/q_cycle_sequencer.sv
// Four-phase Q-cycle sequencer with instruction register, class decode,
// skip/goto squash and SLEEP/wake handling.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-high
//   inst_in        program memory word at the current PC
//   skip           squash the next executed instruction (sampled at the q=0 edge)
//   wake           level; leaves sleep, or blocks a SLEEP from taking effect
//   IR             instruction register
//   fetch_state    FE code (Q1..Q4, HOLD)
//   execute_state  EX code (Q1..Q3 or Q4 instruction class, SLEEP_IDLE)
//   ir_load        high during the cycle whose closing edge loads IR
//   sleeping       high while asleep
//   retire         one-cycle pulse at Q4 of a non-squashed instruction
module q_cycle_sequencer #(
    parameter int unsigned INST_WIDTH    = 12,
    parameter int unsigned FE_STATE_BITS = 3,
    parameter int unsigned EX_STATE_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_WIDTH-1:0]    inst_in,
    input  logic                     skip,
    input  logic                     wake,
    output logic [INST_WIDTH-1:0]    IR,
    output logic [FE_STATE_BITS-1:0] fetch_state,
    output logic [EX_STATE_BITS-1:0] execute_state,
    output logic                     ir_load,
    output logic                     sleeping,
    output logic                     retire
);

    localparam logic [FE_STATE_BITS-1:0] FE_Q1   = FE_STATE_BITS'(0);
    localparam logic [FE_STATE_BITS-1:0] FE_HOLD = FE_STATE_BITS'(4);

    localparam logic [EX_STATE_BITS-1:0] EX_Q1         = EX_STATE_BITS'(0);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRF    = EX_STATE_BITS'(3);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRW    = EX_STATE_BITS'(4);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_FSZ     = EX_STATE_BITS'(5);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVF    = EX_STATE_BITS'(6);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVWF   = EX_STATE_BITS'(7);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_BXF     = EX_STATE_BITS'(8);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_BTFSX   = EX_STATE_BITS'(9);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CALL    = EX_STATE_BITS'(10);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRWDT  = EX_STATE_BITS'(11);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_GOTO    = EX_STATE_BITS'(12);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVLW   = EX_STATE_BITS'(13);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_OPTION  = EX_STATE_BITS'(14);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_RETLW   = EX_STATE_BITS'(15);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_SLEEP   = EX_STATE_BITS'(16);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_TRIS    = EX_STATE_BITS'(17);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_ELSE    = EX_STATE_BITS'(18);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_ALUXLW  = EX_STATE_BITS'(19);
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_NOP     = EX_STATE_BITS'(20);
    localparam logic [EX_STATE_BITS-1:0] EX_SLEEP_IDLE = EX_STATE_BITS'(21);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } seqState_e;

    seqState_e                  state;
    seqState_e                  stateNext;
    logic [1:0]                 q;
    logic [1:0]                 qNext;
    logic                       squash;
    logic                       squashNext;
    logic [INST_WIDTH-1:0]      irNext;
    logic [FE_STATE_BITS-1:0]   feNext;
    logic [EX_STATE_BITS-1:0]   exNext;
    logic                       irLoadNext;
    logic                       retireNext;
    logic [EX_STATE_BITS-1:0]   irClass;

    // Instruction class of a 12-bit opcode; undefined encodings fall to NOP.
    function automatic logic [EX_STATE_BITS-1:0] decodeClass(input logic [INST_WIDTH-1:0] ins);
        logic [EX_STATE_BITS-1:0] cls;
        cls = EX_Q4_NOP;
        if (ins[11:4] == 8'h00) begin
            case (ins[3:0])
                4'h2:              cls = EX_Q4_OPTION;
                4'h3:              cls = EX_Q4_SLEEP;
                4'h4:              cls = EX_Q4_CLRWDT;
                4'h5, 4'h6, 4'h7:  cls = EX_Q4_TRIS;
                default:           cls = EX_Q4_NOP;
            endcase
        end else if (ins[11:5] == 7'b0000001) begin
            cls = EX_Q4_MOVWF;
        end else if (ins == 12'h040) begin
            cls = EX_Q4_CLRW;
        end else if (ins[11:5] == 7'b0000011) begin
            cls = EX_Q4_CLRF;
        end else if (ins[11:6] == 6'b001000) begin
            cls = EX_Q4_MOVF;
        end else if ((ins[11:6] == 6'b001011) || (ins[11:6] == 6'b001111)) begin
            cls = EX_Q4_FSZ;
        end else if ((ins[11:10] == 2'b00) && (ins[9:6] >= 4'd2)) begin
            // remaining byte-oriented file-register operations
            cls = EX_Q4_ELSE;
        end else begin
            case (ins[11:8])
                4'h4, 4'h5:       cls = EX_Q4_BXF;
                4'h6, 4'h7:       cls = EX_Q4_BTFSX;
                4'h8:             cls = EX_Q4_RETLW;
                4'h9:             cls = EX_Q4_CALL;
                4'hA, 4'hB:       cls = EX_Q4_GOTO;
                4'hC:             cls = EX_Q4_MOVLW;
                4'hD, 4'hE, 4'hF: cls = EX_Q4_ALUXLW;
                default:          cls = EX_Q4_NOP;
            endcase
        end
        return cls;
    endfunction

    assign irClass = decodeClass(IR);

    // State register; outputs are registered from their next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            q             <= 2'd0;
            squash        <= 1'b1;
            IR            <= '0;
            sleeping      <= 1'b0;
            fetch_state   <= FE_Q1;
            execute_state <= EX_Q1;
            ir_load       <= 1'b0;
            retire        <= 1'b0;
        end else begin
            state         <= stateNext;
            q             <= qNext;
            squash        <= squashNext;
            IR            <= irNext;
            sleeping      <= (stateNext == ST_SLEEP);
            fetch_state   <= feNext;
            execute_state <= exNext;
            ir_load       <= irLoadNext;
            retire        <= retireNext;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext  = state;
        qNext      = q;
        squashNext = squash;
        irNext     = IR;
        feNext     = FE_Q1;
        exNext     = EX_Q1;
        irLoadNext = 1'b0;
        retireNext = 1'b0;

        case (state)
            ST_RUN: begin
                qNext = q + 2'd1;
                if ((q == 2'd0) && skip) begin
                    squashNext = 1'b1;
                end
                if (q == 2'd3) begin
                    // Q4 edge: prefetch next word and retire the squash NOP
                    irNext     = inst_in;
                    squashNext = 1'b0;
                    if (!squash && (irClass == EX_Q4_SLEEP) && !wake) begin
                        stateNext = ST_SLEEP;
                    end
                end
            end
            ST_SLEEP: begin
                qNext = 2'd0;
                if (wake) begin
                    stateNext = ST_RUN;
                end
            end
            default: begin
                stateNext = ST_RUN;
                qNext     = 2'd0;
            end
        endcase

        if (stateNext == ST_SLEEP) begin
            feNext = FE_HOLD;
            exNext = EX_SLEEP_IDLE;
        end else begin
            feNext     = FE_STATE_BITS'(qNext);
            irLoadNext = (qNext == 2'd3);
            retireNext = (qNext == 2'd3) && !squashNext;
            if (qNext == 2'd3) begin
                exNext = squashNext ? EX_Q4_NOP : decodeClass(irNext);
            end else begin
                exNext = EX_STATE_BITS'(qNext);
            end
        end
    end

endmodule

// File: tb/tb_q_cycle_sequencer.sv
// Scoreboard bench for q_cycle_sequencer: a phase-level reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_q_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] inst_in;
    logic        skip;
    logic        wake;
    logic [11:0] IR;
    logic [2:0]  fetch_state;
    logic [4:0]  execute_state;
    logic        ir_load;
    logic        sleeping;
    logic        retire;

    always #5 clk = ~clk;

    q_cycle_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .inst_in       (inst_in),
        .skip          (skip),
        .wake          (wake),
        .IR            (IR),
        .fetch_state   (fetch_state),
        .execute_state (execute_state),
        .ir_load       (ir_load),
        .sleeping      (sleeping),
        .retire        (retire)
    );

    typedef struct {
        int fe;
        int ex;
        bit irl;
        bit sl;
        bit ret;
        int ir;
    } expRec_t;

    expRec_t expQ[$];
    int      retQ[$];
    int      checks = 0;
    int      errors = 0;
    bit      monOn  = 1'b0;

    // reference model state: phase, instruction register, pending squash, asleep
    int mQ  = 0;
    int mIr = 0;
    bit mSq = 1'b1;
    bit mSl = 1'b0;

    // opcode class table, first match wins; unmatched -> NOP (20)
    int dMask[23]  = '{'hFFF, 'hFFF, 'hFFF, 'hFFF, 'hFFF, 'hFFE, 'hFE0, 'hFFF,
                       'hFE0, 'hFC0, 'hFC0, 'hFC0, 'hF80, 'hF00, 'hE00, 'hE00,
                       'hE00, 'hF00, 'hF00, 'hE00, 'hF00, 'hF00, 'hE00};
    int dMatch[23] = '{'h000, 'h002, 'h003, 'h004, 'h005, 'h006, 'h020, 'h040,
                       'h060, 'h200, 'h2C0, 'h3C0, 'h080, 'h100, 'h200, 'h400,
                       'h600, 'h800, 'h900, 'hA00, 'hC00, 'hD00, 'hE00};
    int dCode[23]  = '{20, 14, 16, 11, 17, 17, 7, 4,
                       3, 6, 5, 5, 18, 18, 18, 8,
                       9, 15, 10, 12, 13, 19, 19};

    int swIns[17]  = '{'h000, 'h002, 'h003, 'h005, 'h021, 'h040, 'h061, 'h2C1, 'h201,
                       'h0C1, 'h425, 'h6E5, 'h8FF, 'h9FF, 'hC12, 'hE0F, 'h001};
    int swCode[17] = '{20, 14, 16, 17, 7, 4, 3, 5, 6, 18, 8, 9, 15, 10, 13, 19, 20};

    function automatic int refClass(input int ins);
        for (int i = 0; i < 23; i++) begin
            if ((ins & dMask[i]) == dMatch[i]) return dCode[i];
        end
        return 20;
    endfunction

    task automatic pushExp();
        expRec_t e;
        e.sl = mSl;
        e.ir = mIr;
        if (mSl) begin
            e.fe = 4; e.ex = 21; e.irl = 1'b0; e.ret = 1'b0;
        end else begin
            e.fe  = mQ;
            e.irl = (mQ == 3);
            e.ret = (mQ == 3) && !mSq;
            e.ex  = (mQ < 3) ? mQ : (mSq ? 20 : refClass(mIr));
        end
        expQ.push_back(e);
        if (e.ret) retQ.push_back(mIr);
    endtask

    // Advance the model across one clock edge.
    task automatic modelStep(input bit r, input int ins, input bit s, input bit w);
        if (r) begin
            mQ = 0; mIr = 0; mSq = 1'b1; mSl = 1'b0;
        end else if (mSl) begin
            if (w) mSl = 1'b0;
        end else if (mQ == 3) begin
            if (!mSq && (refClass(mIr) == 16) && !w) mSl = 1'b1;
            mIr = ins;
            mSq = 1'b0;
            mQ  = 0;
        end else begin
            if ((mQ == 0) && s) mSq = 1'b1;
            mQ = mQ + 1;
        end
        pushExp();
    endtask

    task automatic tick(input bit r, input int ins, input bit s, input bit w);
        rst     = r;
        inst_in = 12'(ins);
        skip    = s;
        wake    = w;
        modelStep(r, ins, s, w);
        @(posedge clk);
        #2;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // One full instruction cycle from q=0; optionally checks the Q4 class executed in it.
    task automatic runInstr(input int ins, input bit skipQ0, input bit w, input int expEx);
        for (int k = 0; k < 4; k++) begin
            if (expEx >= 0 && mQ == 3 && !mSl) checkVal("q4_class", 32'(execute_state), 32'(expEx));
            tick(1'b0, ins, skipQ0 && (mQ == 0), w);
        end
    endtask

    expRec_t monE;
    int      monR;

    // Monitor: every cycle compare against the model; every retire against the retire queue.
    always @(negedge clk) begin
        if (monOn) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL cycle_queue actual empty required entry at %0t", $time);
            end else begin
                monE = expQ.pop_front();
                if (fetch_state !== 3'(monE.fe) || execute_state !== 5'(monE.ex) ||
                    ir_load !== monE.irl || sleeping !== monE.sl || retire !== monE.ret ||
                    IR !== 12'(monE.ir)) begin
                    errors++;
                    $display("FAIL cycle at %0t actual fe=%0d ex=%0d irl=%0b sl=%0b ret=%0b ir=%h required fe=%0d ex=%0d irl=%0b sl=%0b ret=%0b ir=%h",
                             $time, fetch_state, execute_state, ir_load, sleeping, retire, IR,
                             monE.fe, monE.ex, monE.irl, monE.sl, monE.ret, 12'(monE.ir));
                end
            end
            if (retire === 1'b1) begin
                checks++;
                if (retQ.size() == 0) begin
                    errors++;
                    $display("FAIL retire_queue actual retire required none at %0t", $time);
                end else begin
                    monR = retQ.pop_front();
                    if (IR !== 12'(monR)) begin
                        errors++;
                        $display("FAIL retire_ir actual %h required %h at %0t", IR, 12'(monR), $time);
                    end
                end
            end
        end
    end

    int sleepCnt;

    initial begin
        // reset for two clocks
        tick(1'b1, 0, 1'b0, 1'b0);
        monOn = 1'b1;
        tick(1'b1, 0, 1'b0, 1'b0);
        checkVal("reset_fe", 32'(fetch_state), 32'd0);
        checkVal("reset_ex", 32'(execute_state), 32'd0);
        checkVal("reset_ir", 32'(IR), 32'd0);

        // first instruction cycle after reset is squashed
        runInstr('h000, 1'b0, 1'b1, -1);

        // GOTO, then skip squashes the following instruction
        runInstr('hA25, 1'b0, 1'b1, 20);
        runInstr('hC12, 1'b0, 1'b1, 12);
        runInstr('hE0F, 1'b1, 1'b1, 20);
        runInstr('h000, 1'b0, 1'b1, 19);

        // decode sweep
        for (int i = 0; i < 17; i++) runInstr(swIns[i], 1'b0, 1'b1, (i == 0) ? 20 : swCode[i-1]);
        runInstr('h000, 1'b0, 1'b1, swCode[16]);

        // SLEEP with wake low, hold 10 clocks, then wake
        runInstr('h003, 1'b0, 1'b0, -1);
        runInstr('h000, 1'b0, 1'b0, 16);
        sleepCnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (sleeping === 1'b1 && fetch_state === 3'd4 && execute_state === 5'd21) sleepCnt++;
            tick(1'b0, 'h000, 1'b1, 1'b0);
        end
        checkVal("sleep_hold_cycles", 32'(sleepCnt), 32'd10);
        tick(1'b0, 'h000, 1'b0, 1'b1);
        checkVal("wake_fe", 32'(fetch_state), 32'd0);
        checkVal("wake_sleeping", 32'(sleeping), 32'd0);
        runInstr('h000, 1'b0, 1'b1, 20);

        // reset mid-instruction at q=2
        runInstr('h8FF, 1'b0, 1'b1, -1);
        tick(1'b0, 'h8FF, 1'b0, 1'b1);
        tick(1'b0, 'h8FF, 1'b0, 1'b1);
        tick(1'b1, 'h8FF, 1'b0, 1'b1);
        checkVal("midrst_fe", 32'(fetch_state), 32'd0);
        checkVal("midrst_ex", 32'(execute_state), 32'd0);
        checkVal("midrst_ir", 32'(IR), 32'd0);
        runInstr('h425, 1'b0, 1'b1, 20);

        // SLEEP with wake high in the same cycle: no sleep
        runInstr('h003, 1'b0, 1'b1, -1);
        runInstr('h000, 1'b0, 1'b1, 16);
        checkVal("nosleep_sleeping", 32'(sleeping), 32'd0);
        checkVal("nosleep_fe", 32'(fetch_state), 32'd0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            tick($urandom_range(0, 199) == 0,
                 ($urandom_range(0, 5) == 0) ? 'h003 : int'($urandom_range(0, 4095)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        #1;
        checkVal("queues_drained", 32'(expQ.size() + retQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
